// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: fetch, debug and instruction-memory signals shared by the arbiter and its neighbours.
interface imem_arbiter_if #(
    parameter int W     = 32,
    parameter int IDX_W = 11
);
    logic             f_req;
    logic [W-1:0]     f_addr;
    logic             f_gnt;
    logic             f_rvalid;
    logic [W-1:0]     f_rdata;
    logic             f_err;
    logic             d_req;
    logic             d_we;
    logic [W-1:0]     d_addr;
    logic [W-1:0]     d_wdata;
    logic             d_lock;
    logic             d_gnt;
    logic             d_rvalid;
    logic [W-1:0]     d_rdata;
    logic             d_err;
    logic             mem_en;
    logic             mem_we;
    logic [IDX_W-1:0] mem_idx;
    logic [W-1:0]     mem_wdata;
    logic [W-1:0]     mem_rdata;

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, d_lock, mem_rdata,
        input  f_gnt, f_rvalid, f_rdata, f_err, d_gnt, d_rvalid, d_rdata, d_err,
               mem_en, mem_we, mem_idx, mem_wdata
    );

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, d_lock, mem_rdata,
        output f_gnt, f_rvalid, f_rdata, f_err, d_gnt, d_rvalid, d_rdata, d_err,
               mem_en, mem_we, mem_idx, mem_wdata
    );
endinterface

// File: rtl/imem_arbiter.sv
// imem_arbiter: round-robin sharing of one single-port instruction memory between fetch and debug,
// one grant per cycle with the response one cycle later; bad addresses fault without a memory access.
module imem_arbiter #(
    parameter int W         = 32,
    parameter int IMEM_SIZE = 128,
    parameter int IDX_W     = 11
) (
    input  logic           clk,
    input  logic           rst_n,
    imem_arbiter_if.slave  bus
);
    logic         f_elig, f_gnt, d_gnt, gnt, ok;
    logic         rr;
    logic [W-1:0] addr;
    logic         f_rv, f_er, f_rd, d_rv, d_er, d_rd;
    logic [W-1:0] f_hold, d_hold, f_data, d_data;

    // rr=1 means the last grant went to debug, so fetch wins the next tie
    always_comb begin
        f_elig = bus.f_req & ~bus.d_lock;
        d_gnt  = bus.d_req & (~f_elig | ~rr);
        f_gnt  = f_elig & ~d_gnt;
        gnt    = f_gnt | d_gnt;
        addr   = d_gnt ? bus.d_addr : bus.f_addr;
        ok     = addr[1:0] == 2'b00 && (addr >> 2) < W'(IMEM_SIZE);
        f_data = f_rv ? (f_rd ? bus.mem_rdata : '0) : f_hold;
        d_data = d_rv ? (d_rd ? bus.mem_rdata : '0) : d_hold;
    end

    assign bus.f_gnt     = f_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.mem_en    = gnt & ok;
    assign bus.mem_we    = gnt & ok & d_gnt & bus.d_we;
    assign bus.mem_idx   = gnt ? addr[IDX_W+1:2] : '0;
    assign bus.mem_wdata = gnt ? bus.d_wdata : '0;
    assign bus.f_rvalid  = f_rv;
    assign bus.f_rdata   = f_data;
    assign bus.f_err     = f_er;
    assign bus.d_rvalid  = d_rv;
    assign bus.d_rdata   = d_data;
    assign bus.d_err     = d_er;

    // read data arrives from memory in the response cycle, so rdata is muxed live and held afterwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr     <= 1'b0;
            f_rv   <= 1'b0;
            f_er   <= 1'b0;
            f_rd   <= 1'b0;
            d_rv   <= 1'b0;
            d_er   <= 1'b0;
            d_rd   <= 1'b0;
            f_hold <= '0;
            d_hold <= '0;
        end else begin
            if (gnt) rr <= d_gnt;
            f_rv <= f_gnt;
            d_rv <= d_gnt;
            if (f_gnt) begin
                f_er <= ~ok;
                f_rd <= ok;
            end
            if (d_gnt) begin
                d_er <= ~ok;
                d_rd <= ok & ~bus.d_we;
            end
            f_hold <= f_data;
            d_hold <= d_data;
        end
    end
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed steps against a reference grant/memory model with a response scoreboard.
module tb_imem_arbiter;
    typedef struct {
        logic        dbg;
        logic [31:0] data;
        logic        err;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] mem     [128];
    logic [31:0] ref_mem [128];
    resp_t       sb [$];
    logic        m_rr;
    logic [31:0] last_f, last_d;
    logic        last_fe, last_de;

    imem_arbiter_if bus ();
    imem_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // memory macro: synchronous, write-first
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                mem[bus.mem_idx[6:0]] <= bus.mem_wdata;
                bus.mem_rdata         <= bus.mem_wdata;
            end else begin
                bus.mem_rdata <= mem[bus.mem_idx[6:0]];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic        fel, dg, fg, ok;
        logic [31:0] a;
        resp_t       r;
        fel = bus.f_req & ~bus.d_lock;
        dg  = bus.d_req & (~fel | ~m_rr);
        fg  = fel & ~dg;
        a   = dg ? bus.d_addr : bus.f_addr;
        ok  = (a[1:0] == 2'b00) && ((a >> 2) < 32'd128);
        #1;
        chk("f_gnt", bus.f_gnt, fg);
        chk("d_gnt", bus.d_gnt, dg);
        chk("mem_en", bus.mem_en, (fg | dg) & ok);
        chk("mem_we", bus.mem_we, dg & ok & bus.d_we);
        if ((fg | dg) && ok) chk("mem_idx", bus.mem_idx, a >> 2);
        if (dg && ok && bus.d_we) chk("mem_wdata", bus.mem_wdata, bus.d_wdata);
        if (fg | dg) begin
            r.dbg  = dg;
            r.err  = !ok;
            r.data = (ok && !(dg && bus.d_we)) ? ref_mem[a[8:2]] : 32'h0;
            if (ok && dg && bus.d_we) ref_mem[a[8:2]] = bus.d_wdata;
            sb.push_back(r);
            m_rr = dg;
        end
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            r = sb.pop_front();
            if (r.dbg) begin
                chk("d_rvalid", bus.d_rvalid, 1);
                chk("d_rdata", bus.d_rdata, r.data);
                chk("d_err", bus.d_err, r.err);
                chk("f_rvalid_idle", bus.f_rvalid, 0);
                last_d  = r.data;
                last_de = r.err;
            end else begin
                chk("f_rvalid", bus.f_rvalid, 1);
                chk("f_rdata", bus.f_rdata, r.data);
                chk("f_err", bus.f_err, r.err);
                chk("d_rvalid_idle", bus.d_rvalid, 0);
                last_f  = r.data;
                last_fe = r.err;
            end
        end else begin
            chk("f_rvalid_none", bus.f_rvalid, 0);
            chk("d_rvalid_none", bus.d_rvalid, 0);
            chk("f_rdata_hold", bus.f_rdata, last_f);
            chk("f_err_hold", bus.f_err, last_fe);
            chk("d_rdata_hold", bus.d_rdata, last_d);
            chk("d_err_hold", bus.d_err, last_de);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_f_rvalid", bus.f_rvalid, 0);
        chk("rst_f_rdata", bus.f_rdata, 0);
        chk("rst_f_err", bus.f_err, 0);
        chk("rst_d_rvalid", bus.d_rvalid, 0);
        chk("rst_d_rdata", bus.d_rdata, 0);
        chk("rst_d_err", bus.d_err, 0);
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_gnt", {bus.f_gnt, bus.d_gnt}, 0);
    endtask

    task automatic clear_model();
        m_rr    = 1'b0;
        sb.delete();
        last_f  = 0;
        last_d  = 0;
        last_fe = 0;
        last_de = 0;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            mem[i]     = (i * 32'h01010101) ^ 32'h00001000;
            ref_mem[i] = (i * 32'h01010101) ^ 32'h00001000;
        end
        mem[2]     = 32'h24080005;
        ref_mem[2] = 32'h24080005;
        rst_n       = 1'b0;
        bus.f_req   = 0;
        bus.f_addr  = 0;
        bus.d_req   = 0;
        bus.d_we    = 0;
        bus.d_addr  = 0;
        bus.d_wdata = 0;
        bus.d_lock  = 0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs();
        rst_n = 1'b1;

        // fetch of word 2
        bus.f_req  = 1;
        bus.f_addr = 32'h8;
        tick();
        bus.f_req = 0;

        // debug write then read-after-write of the same word
        bus.d_req   = 1;
        bus.d_we    = 1;
        bus.d_addr  = 32'h10;
        bus.d_wdata = 32'hDEADBEEF;
        tick();
        bus.d_we = 0;
        tick();
        bus.d_req = 0;
        tick();

        // reset in the cycle after a fetch grant
        bus.f_req  = 1;
        bus.f_addr = 32'h8;
        #1;
        chk("pre_rst_f_gnt", bus.f_gnt, 1);
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        bus.f_req = 0;
        #1;
        chk_reset_outputs();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs();
        rst_n = 1'b1;
        clear_model();
        tick();

        // both requesting from reset: D,F,D,F
        bus.f_req  = 1;
        bus.f_addr = 32'h8;
        bus.d_req  = 1;
        bus.d_addr = 32'h10;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("tie_order", bus.d_rvalid, (i % 2 == 0) ? 1 : 0);
        end
        bus.d_req = 0;

        // lock blocks fetch, fetch proceeds once lock drops
        bus.d_lock = 1;
        bus.f_addr = 32'h4;
        repeat (3) tick();
        bus.d_req  = 1;
        bus.d_addr = 32'h1FC;
        tick();
        bus.d_req  = 0;
        bus.d_lock = 0;
        tick();

        // address faults: misaligned, out of range, high bits not aliased
        bus.f_addr = 32'h6;
        tick();
        bus.f_addr = 32'h200;
        tick();
        bus.f_addr = 32'h80000008;
        tick();
        bus.f_req   = 0;
        bus.d_req   = 1;
        bus.d_we    = 1;
        bus.d_addr  = 32'h13;
        bus.d_wdata = 32'h12345678;
        tick();
        bus.d_we   = 0;
        bus.d_addr = 32'h1FC;
        tick();
        bus.d_req = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares one single-port, word-addressed instruction memory between two requesters: the CPU fetch unit (read-only) and the debug/loader port (read/write).
- Sits between the multicycle core's fetch stage and the instruction memory macro.
- Arbitrates per cycle, sequences accesses, and registers the read data and valid flags.
- Rejects misaligned and out-of-range addresses without touching memory.

Parameters:
- W, 32, data and byte-address width.
- IMEM_SIZE, 128, memory depth in words.
- IDX_W, 11, memory word-index width; the index is addr[IDX_W+1:2].

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- f_req  in  1  fetch request, held until f_gnt.
- f_addr  in  W  fetch byte address, stable while f_req.
- f_gnt  out  1  fetch request accepted this cycle.
- f_rvalid  out  1  f_rdata/f_err valid, one-cycle pulse.
- f_rdata  out  W  fetched word.
- f_err  out  1  fetch address fault (misaligned or out of range).
- d_req  in  1  debug request, held until d_gnt.
- d_we  in  1  debug write enable.
- d_addr  in  W  debug byte address.
- d_wdata  in  W  debug write data.
- d_lock  in  1  debug holds memory; fetch is never granted while high.
- d_gnt  out  1  debug request accepted this cycle.
- d_rvalid  out  1  debug response valid; pulses for writes too.
- d_rdata  out  W  debug read data; 0 for writes.
- d_err  out  1  debug address fault.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write.
- mem_idx  out  IDX_W  word index.
- mem_wdata  out  W  write data.
- mem_rdata  in  W  synchronous read data, valid the cycle after mem_en.

Behaviour:
- Reset (rst=0, async): all registered outputs go to 0. That covers f_rvalid, f_rdata, f_err, d_rvalid, d_rdata, d_err, the rr pointer (last grant = fetch) and the pending-response registers.
- Grant logic (combinational from req, d_lock and the rr register):
  - At most one of f_gnt/d_gnt is high per cycle.
  - Fetch is eligible only when f_req=1 and d_lock=0.
  - If only one requester is eligible, it wins.
  - If both are eligible, round-robin: the requester not granted last wins. After reset, debug wins the first tie.
  - The rr register updates on every grant.
- Access issue in grant cycle N:
  - If the address is aligned (addr[1:0]=0) and idx < IMEM_SIZE: mem_en=1, mem_idx=idx, mem_we=d_we for debug and 0 for fetch, mem_wdata=d_wdata.
  - Otherwise mem_en=0 and a fault response is queued.
  - With no grant: mem_en=0, mem_we=0, mem_idx=0, mem_wdata=0.
- Response in cycle N+1:
  - The granted port's rvalid=1.
  - rdata = mem_rdata for a good read, 0 for a write or fault.
  - err=1 only for a fault.
  - The other port's rvalid=0. rdata/err hold their last value while rvalid=0.
- Throughput: one grant per cycle, fully pipelined. Back-to-back grants produce back-to-back responses in order.
- Read-after-write from debug in consecutive cycles returns the new data; the memory is write-first. The bench models it so.
- Protocol: requesters deassert req or change the address only in the cycle after gnt. A req dropped without gnt is legal; nothing is issued.
- d_lock rises while a fetch response is pending: that response still completes in N+1.
- d_lock and f_req high with d_req low: no grant, mem idle.
- Reset mid-access: the pending response is discarded and no rvalid follows reset release.
- Wrap-around: none. An address at or above IMEM_SIZE*4 faults; its upper bits are not aliased.

Test Plan:
- Reset then f_req=1, f_addr=0x8, mem[2]=0x24080005 -> f_gnt in cycle 1, f_rvalid=1 with f_rdata=0x24080005 and f_err=0 in cycle 2.
- d_req=1, d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF, then a debug read of 0x10 next cycle -> mem_we=1 and mem_idx=4 in the first cycle; read returns 0xDEADBEEF; write response has d_rdata=0.
- f_req and d_req held high together for 4 cycles from reset -> grants go D,F,D,F and responses go to the matching ports each following cycle.
- d_lock=1 with f_req=1 for 3 cycles -> f_gnt stays 0 and mem_en stays 0; after d_lock drops, fetch is granted the next cycle.
- f_addr=0x6 (misaligned), then f_addr=0x200 (idx 128, out of range) -> mem_en=0 in both grant cycles; f_rvalid=1, f_err=1, f_rdata=0 in each response.
- rst pulled low in the cycle after a fetch grant -> no f_rvalid after release, and all outputs read 0 during reset.
